// File: rtl/bram11_ctrl.sv
// bram11_ctrl: single-outstanding command front end for a DEPTH-word, 32-bit, 1-cycle-latency BRAM.
// Optional zero-fill engine is compiled in when BRAM11_CTRL_CLEAR_EN is defined.
module bram11_ctrl #(
    parameter int DEPTH  = 11,
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [3:0]        cmd_strb,
    input  logic [3:0]        cmd_idx,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    input  logic              clr_start,
    output logic              busy,
    output logic              bram_EN,
    output logic [3:0]        bram_WE,
    output logic [ADDR_W-1:0] bram_A,
    output logic [31:0]       bram_Di,
    input  logic [31:0]       bram_Do
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        RSP     = 3'd3
`ifdef BRAM11_CTRL_CLEAR_EN
        , CLR   = 3'd4
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                is_write_q, is_write_d;
    logic                cmd_fire, in_range;
    logic                rsp_valid_d, rsp_err_d;
    logic [31:0]         rsp_rdata_d, bram_di_d;
    logic                bram_en_d;
    logic [3:0]          bram_we_d;
    logic [ADDR_W-1:0]   bram_a_d;

    // Handshakes: a transfer happens on a posedge where valid and ready are both high;
    // once raised, rsp_valid and its payload hold until rsp_ready completes the transfer.
`ifdef BRAM11_CTRL_CLEAR_EN
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic [CNT_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic                busy_d, clr_go;
    assign clr_go    = (state_q == IDLE) && clr_start;
    assign cmd_ready = (state_q == IDLE) && !RST && !clr_start;
`else
    logic                unused_clr;
    assign unused_clr = clr_start;
    assign busy       = 1'b0;
    assign cmd_ready  = (state_q == IDLE) && !RST;
`endif

    assign cmd_fire = cmd_valid && cmd_ready;
    assign in_range = 32'(cmd_idx) < DEPTH;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
`ifdef BRAM11_CTRL_CLEAR_EN
                if (clr_go) state_d = CLR; else
`endif
                if (cmd_fire) state_d = in_range ? ISSUE : RSP;
            end
            ISSUE:   state_d = is_write_q ? RSP : CAPTURE;
            CAPTURE: state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
`ifdef BRAM11_CTRL_CLEAR_EN
            CLR:     if (clr_cnt_q == CNT_W'(DEPTH - 1)) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; anything not driven here returns to 0.
    always_comb begin
        is_write_d  = is_write_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        bram_en_d   = 1'b0;
        bram_we_d   = 4'h0;
        bram_a_d    = '0;
        bram_di_d   = 32'h0;
`ifdef BRAM11_CTRL_CLEAR_EN
        busy_d      = 1'b0;
        clr_cnt_d   = clr_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef BRAM11_CTRL_CLEAR_EN
                if (clr_go) begin
                    bram_en_d = 1'b1;
                    bram_we_d = 4'hF;
                    busy_d    = 1'b1;
                    clr_cnt_d = '0;
                end else
`endif
                if (cmd_fire) begin
                    if (in_range) begin
                        bram_en_d  = 1'b1;
                        bram_a_d   = ADDR_W'({cmd_idx, 2'b00});
                        bram_di_d  = cmd_wdata;
                        bram_we_d  = cmd_we ? cmd_strb : 4'h0;
                        is_write_d = cmd_we;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (is_write_q) begin
                    rsp_valid_d = 1'b1;
                end else begin
                    bram_en_d = 1'b1;
                    bram_a_d  = bram_A;
                end
            end
            CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = bram_Do;
            end
            RSP: begin
                if (!rsp_ready) begin
                    rsp_valid_d = rsp_valid;
                    rsp_err_d   = rsp_err;
                    rsp_rdata_d = rsp_rdata;
                end
            end
`ifdef BRAM11_CTRL_CLEAR_EN
            CLR: begin
                if (clr_cnt_q != CNT_W'(DEPTH - 1)) begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    bram_en_d = 1'b1;
                    bram_we_d = 4'hF;
                    bram_a_d  = ADDR_W'({clr_cnt_d, 2'b00});
                    busy_d    = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
            bram_EN    <= 1'b0;
            bram_WE    <= 4'h0;
            bram_A     <= '0;
            bram_Di    <= 32'h0;
`ifdef BRAM11_CTRL_CLEAR_EN
            busy       <= 1'b0;
            clr_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            rsp_valid  <= rsp_valid_d;
            rsp_err    <= rsp_err_d;
            rsp_rdata  <= rsp_rdata_d;
            bram_EN    <= bram_en_d;
            bram_WE    <= bram_we_d;
            bram_A     <= bram_a_d;
            bram_Di    <= bram_di_d;
`ifdef BRAM11_CTRL_CLEAR_EN
            busy       <= busy_d;
            clr_cnt_q  <= clr_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_bram11_ctrl.sv
// Self-checking bench for bram11_ctrl: behavioural BRAM, word-array reference model and response scoreboard.
// Zero-fill scenarios are exercised when BRAM11_CTRL_CLEAR_EN is defined.
module tb_bram11_ctrl;

    localparam int DEPTH  = 11;
    localparam int ADDR_W = 12;

    logic              CLK, RST;
    logic              cmd_valid, cmd_ready, cmd_we;
    logic [3:0]        cmd_strb, cmd_idx;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_rdata;
    logic              clr_start, busy;
    logic              bram_EN;
    logic [3:0]        bram_WE;
    logic [ADDR_W-1:0] bram_A;
    logic [31:0]       bram_Di, bram_Do;

    bram11_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_strb(cmd_strb), .cmd_idx(cmd_idx), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .clr_start(clr_start), .busy(busy),
        .bram_EN(bram_EN), .bram_WE(bram_WE), .bram_A(bram_A), .bram_Di(bram_Di), .bram_Do(bram_Do)
    );

    // ---------------- clock / cycle counter ----------------
    int cyc = 0;
    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- behavioural BRAM (read-first, 1-cycle latency) ----------------
    logic [31:0] mem [0:15];
    logic [31:0] dout;
    always @(posedge CLK) begin
        if (bram_EN) begin
            dout <= mem[bram_A[5:2]];
            for (int b = 0; b < 4; b++)
                if (bram_WE[b]) mem[bram_A[5:2]][8*b +: 8] <= bram_Di[8*b +: 8];
        end
    end
    assign bram_Do = bram_EN ? dout : 32'h0;

    // ---------------- reference model and scoreboard ----------------
    logic [31:0] ref_mem [0:15];
    logic [32:0] exp_q[$];
    int          exp_cyc_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // rsp_ready driver
    initial begin
        rsp_ready = 0;
        forever begin
            @(negedge CLK);
            case (rdy_mode)
                0:       rsp_ready = ($urandom_range(0, 2) != 0);
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Response monitor
    logic        in_rsp = 0, drop_chk = 0;
    logic [32:0] held;
    initial begin
        logic [32:0] e;
        int          c;
        forever begin
            @(negedge CLK);
            #1;
            if (RST) begin
                in_rsp   = 0;
                drop_chk = 0;
            end else if (drop_chk) begin
                chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
                drop_chk = 0;
            end else if (rsp_valid) begin
                chk("cmd_ready_in_rsp", 64'(cmd_ready), 64'd0);
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'({rsp_err, rsp_rdata}), 64'h1_FFFF_FFFF_F);
                    end else begin
                        e = exp_q.pop_front();
                        c = exp_cyc_q.pop_front();
                        chk("rsp_err", 64'(rsp_err), 64'(e[32]));
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
                        chk("rsp_latency", 64'(cyc), 64'(c));
                    end
                    in_rsp = 1;
                    held   = {rsp_err, rsp_rdata};
                end else begin
                    chk("rsp_stable", 64'({rsp_err, rsp_rdata}), 64'(held));
                end
                if (rsp_ready) begin
                    in_rsp   = 0;
                    drop_chk = 1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic we, input logic [3:0] strb, input logic [3:0] idx,
                        input logic [31:0] wdata, input bit abort, output int acc);
        int          waited;
        bit          ok;
        logic        rng;
        logic [31:0] w;
        @(negedge CLK);
        cmd_valid = 1; cmd_we = we; cmd_strb = strb; cmd_idx = idx; cmd_wdata = wdata;
        waited = 0;
        ok     = 0;
        while (!ok && waited < 200) begin
            #1;
            if (cmd_ready) ok = 1;
            else begin
                @(negedge CLK);
                waited++;
            end
        end
        if (!ok) begin
            chk("cmd_accept_timeout", 64'(waited), 64'd0);
            cmd_valid = 0;
            acc = -1;
            return;
        end
        acc = cyc;
        rng = (int'(idx) < DEPTH);
        if (!abort) begin
            if (!rng) begin
                exp_q.push_back({1'b1, 32'h0});
                exp_cyc_q.push_back(acc + 1);
            end else if (we) begin
                w = ref_mem[idx];
                for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
                ref_mem[idx] = w;
                exp_q.push_back({1'b0, 32'h0});
                exp_cyc_q.push_back(acc + 2);
            end else begin
                exp_q.push_back({1'b0, ref_mem[idx]});
                exp_cyc_q.push_back(acc + 3);
            end
        end
        @(negedge CLK);
        cmd_valid = 0;
        if (abort) RST = 1;
        #1;
        if (rng) begin
            chk("issue_en", 64'(bram_EN), 64'd1);
            chk("issue_addr", 64'(bram_A), 64'(idx) * 4);
            chk("issue_we", 64'(bram_WE), we ? 64'(strb) : 64'd0);
            chk("issue_di", 64'(bram_Di), 64'(wdata));
        end else begin
            chk("err_no_en", 64'(bram_EN), 64'd0);
        end
        if (abort) begin
            @(negedge CLK);
            #1;
            chk("abort_en", 64'(bram_EN), 64'd0);
            chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
            RST = 0;
        end else if (rng && we) begin
            @(negedge CLK);
            #1;
            chk("wr_en_off", 64'(bram_EN), 64'd0);
        end else if (rng) begin
            @(negedge CLK);
            #1;
            chk("cap_en", 64'(bram_EN), 64'd1);
            chk("cap_we", 64'(bram_WE), 64'd0);
            chk("cap_addr", 64'(bram_A), 64'(idx) * 4);
            @(negedge CLK);
            #1;
            chk("rd_en_off", 64'(bram_EN), 64'd0);
        end
    endtask

`ifdef BRAM11_CTRL_CLEAR_EN
    // rst_cyc < 0: full clear; otherwise RST is sampled at the edge that would start that clear cycle.
    task automatic do_clear(input int rst_cyc);
        @(negedge CLK);
        clr_start = 1; cmd_valid = 1; cmd_we = 0; cmd_idx = 4'd3;
        #1;
        chk("clr_prio_ready", 64'(cmd_ready), 64'd0);
        @(negedge CLK);
        clr_start = 0; cmd_valid = 0;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            chk("clr_en", 64'(bram_EN), 64'd1);
            chk("clr_we", 64'(bram_WE), 64'hF);
            chk("clr_addr", 64'(bram_A), 64'(k) * 4);
            chk("clr_di", 64'(bram_Di), 64'd0);
            chk("clr_busy", 64'(busy), 64'd1);
            chk("clr_ready", 64'(cmd_ready), 64'd0);
            ref_mem[k] = 32'h0;
            if (k == rst_cyc - 1) begin
                RST = 1;
                @(negedge CLK);
                #1;
                chk("clr_rst_en", 64'(bram_EN), 64'd0);
                chk("clr_rst_busy", 64'(busy), 64'd0);
                RST = 0;
                return;
            end
            @(negedge CLK);
        end
        #1;
        chk("clr_done_en", 64'(bram_EN), 64'd0);
        chk("clr_done_busy", 64'(busy), 64'd0);
        chk("clr_done_ready", 64'(cmd_ready), 64'd1);
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        int a0, a1, a2, a3, a4, w;
        RST = 1; cmd_valid = 0; cmd_we = 0; cmd_strb = 0; cmd_idx = 0; cmd_wdata = 0; clr_start = 0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_en", 64'(bram_EN), 64'd0);
        chk("rst_we", 64'(bram_WE), 64'd0);
        chk("rst_addr", 64'(bram_A), 64'd0);
        chk("rst_di", 64'(bram_Di), 64'd0);
        @(negedge CLK);
        RST = 0;
        #1;
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < DEPTH; i++) send(1, 4'hF, 4'(i), $urandom, 0, a0);

        // directed write / read / partial write / zero strobe / out of range
        send(1, 4'hF, 4'd3, 32'hDEADBEEF, 0, a0);
        send(0, 4'h0, 4'd3, 32'h0, 0, a0);
        send(1, 4'h2, 4'd3, 32'h0000AA00, 0, a0);
        send(0, 4'h0, 4'd3, 32'h0, 0, a0);
        send(1, 4'h0, 4'd4, 32'h12345678, 0, a0);
        send(0, 4'h0, 4'd4, 32'h0, 0, a0);
        send(0, 4'h0, 4'd11, 32'h0, 0, a0);
        send(0, 4'h0, 4'd15, 32'h0, 0, a0);
        send(1, 4'hF, 4'd12, 32'hCAFEF00D, 0, a0);
        send(0, 4'h0, 4'd10, 32'h0, 0, a0);

        // back-to-back transaction period with rsp_ready held high
        rdy_mode = 1;
        repeat (4) @(negedge CLK);
        send(0, 4'h0, 4'd13, 32'h0, 0, a0);
        send(0, 4'h0, 4'd14, 32'h0, 0, a1);
        send(1, 4'hF, 4'd7, 32'h0BADCAFE, 0, a2);
        send(0, 4'h0, 4'd7, 32'h0, 0, a3);
        send(0, 4'h0, 4'd11, 32'h0, 0, a4);
        chk("period_err", 64'(a1 - a0), 64'd2);
        chk("period_err_to_wr", 64'(a2 - a1), 64'd2);
        chk("period_wr", 64'(a3 - a2), 64'd3);
        chk("period_rd", 64'(a4 - a3), 64'd4);

        // response back-pressure
        rdy_mode = 2;
        repeat (2) @(negedge CLK);
        send(0, 4'h0, 4'd3, 32'h0, 0, a0);
        repeat (5) begin
            @(negedge CLK);
            #1;
            chk("hold_valid", 64'(rsp_valid), 64'd1);
        end
        rdy_mode = 1;
        repeat (3) @(negedge CLK);

        // reset in the middle of a read abandons it
        send(0, 4'h0, 4'd5, 32'h0, 1, a0);
        send(0, 4'h0, 4'd5, 32'h0, 0, a0);

`ifdef BRAM11_CTRL_CLEAR_EN
        do_clear(-1);
        for (int i = 0; i < DEPTH; i++) send(0, 4'h0, 4'(i), 32'h0, 0, a0);
        for (int i = 0; i < DEPTH; i++) send(1, 4'hF, 4'(i), $urandom, 0, a0);
        do_clear(5);
        for (int i = 0; i < DEPTH; i++) send(0, 4'h0, 4'(i), 32'h0, 0, a0);
`else
        clr_start = 1;
        send(1, 4'hF, 4'd6, 32'h600D600D, 0, a0);
        chk("busy_tied", 64'(busy), 64'd0);
        clr_start = 0;
        send(0, 4'h0, 4'd6, 32'h0, 0, a0);
`endif

        // randomized traffic with random back-pressure
        rdy_mode = 0;
        for (int i = 0; i < 80; i++)
            send($urandom_range(0, 1), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom, 0, a0);

        rdy_mode = 1;
        w = 0;
        while ((exp_q.size() != 0 || rsp_valid) && w < 100) begin
            @(negedge CLK);
            w++;
        end
        repeat (2) @(negedge CLK);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram11_ctrl.md
BRAM11_CTRL -- requirements
Module: bram11_ctrl

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 11: number of 32-bit words in the attached BRAM.
- ADDR_W, default 12: BRAM byte-address width.
REQ-002 Ports SHALL be:
- CLK  in  1  single clock; all logic on posedge.
- RST  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept.
- cmd_we  in  1  1=write, 0=read.
- cmd_strb  in  4  byte write enables.
- cmd_idx  in  4  word index.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  index out of range.
- clr_start  in  1  start zero-fill (see Configuration).
- busy  out  1  zero-fill in progress.
- bram_EN  out  1  BRAM enable.
- bram_WE  out  4  BRAM byte write enables.
- bram_A  out  ADDR_W  BRAM byte address.
- bram_Di  out  32  BRAM write data.
- bram_Do  in  32  BRAM read data; 1-cycle latency from address; masked to 0 whenever bram_EN=0.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, CAPTURE, RSP, CLR.
REQ-004 cmd_ready SHALL be 1 only in IDLE with RST=0.
- Handshake: cmd_valid and cmd_ready both high at a posedge.
- At most one transaction SHALL be outstanding.
REQ-005 All bram_* outputs SHALL be registered and SHALL be 0 in IDLE and RSP.
REQ-006 On accepting a command with cmd_idx < DEPTH (cycle N), the block SHALL go to ISSUE in cycle N+1 and drive:
- bram_EN=1
- bram_A={cmd_idx,2'b00} zero-extended to ADDR_W
- bram_Di=cmd_wdata
- bram_WE=cmd_strb for a write, 4'h0 for a read
REQ-007 Write SHALL go ISSUE -> RSP, with rsp_valid=1, rsp_rdata=0, rsp_err=0 from cycle N+2.
REQ-008 Read SHALL go ISSUE -> CAPTURE (cycle N+2) then -> RSP.
- CAPTURE SHALL hold bram_EN=1, bram_WE=0, bram_A unchanged.
- bram_Do SHALL be latched at the end of CAPTURE.
- rsp_valid=1 SHALL assert from cycle N+3 with the latched data.
REQ-009 A write with cmd_strb=4'h0 SHALL still perform the ISSUE cycle (no RAM change) and return a normal response.
REQ-010 A command with cmd_idx >= DEPTH SHALL:
- cause no BRAM access;
- go directly to RSP with rsp_err=1, rsp_rdata=0, rsp_valid=1 from cycle N+1.
REQ-011 In RSP, rsp_valid/rsp_rdata/rsp_err SHALL hold stable until rsp_ready=1 at a posedge; the block then SHALL return to IDLE with rsp_valid=0 in the next cycle.
REQ-012 rsp_ready=1 while rsp_valid=0 SHALL have no effect.
REQ-013 Minimum transaction period SHALL be: read 4 cycles, write 3 cycles, error 2 cycles (rsp_ready held high).

Reset
REQ-014 While RST=1 at a posedge, the following SHALL reset:
- state to IDLE;
- cmd_ready, rsp_valid, rsp_err, busy, bram_EN to 0;
- rsp_rdata, bram_WE, bram_A, bram_Di to 0.
REQ-015 RST asserted mid-transaction or mid-clear SHALL abandon the operation with no response.
- BRAM outputs SHALL be 0 from the next cycle.
- Partially cleared words SHALL remain as written.

Configuration
REQ-016 Macro BRAM11_CTRL_CLEAR_EN SHALL gate the zero-fill feature.
REQ-017 With BRAM11_CTRL_CLEAR_EN defined, clr_start=1 in IDLE SHALL enter CLR.
- clr_start SHALL take priority over a simultaneous cmd_valid; the command is not accepted.
- For DEPTH consecutive cycles, words 0..DEPTH-1 SHALL be written in order with bram_EN=1, bram_WE=4'hF, bram_Di=0.
- Then the block SHALL return to IDLE.
- busy=1 and cmd_ready=0 SHALL hold throughout CLR.
- No response SHALL be produced.
- clr_start outside IDLE SHALL be ignored.
REQ-018 Without BRAM11_CTRL_CLEAR_EN, clr_start SHALL be ignored, busy SHALL be tied 0, and CLR SHALL not exist; ports are unchanged.

Verification
REQ-019 Write idx=3, strb=4'hF, wdata=32'hDEADBEEF:
- ISSUE cycle: bram_A=12'h00C, bram_WE=4'hF.
- rsp_valid at N+2, rsp_err=0.
REQ-020 Then read idx=3:
- bram_EN high for 2 cycles, bram_WE=0.
- rsp_rdata=32'hDEADBEEF at N+3.
REQ-021 Write idx=3, strb=4'h2, wdata=32'h0000AA00, then read idx=3 -> rsp_rdata=32'hDEADAAEF.
REQ-022 Read idx=11 (also idx=15):
- no bram_EN pulse;
- rsp_err=1, rsp_rdata=0 at N+1.
REQ-023 Hold rsp_ready=0 for 5 cycles on a read response -> rsp_* stable and cmd_ready=0 throughout; rsp_valid drops the cycle after rsp_ready=1.
REQ-024 With BRAM11_CTRL_CLEAR_EN, clr_start together with cmd_valid in IDLE:
- 11 write cycles, A=0x000..0x028;
- busy=1 for 11 cycles;
- a subsequent read idx=3 returns 0.
- Repeat with RST asserted at clear cycle 5 -> words 0-4 zero, words 5-10 unchanged.
